stream_gen: RTL and testbench



---
 rtl/stream_gen.sv | 155 +++++++++++++++
 tb/tb_stream_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_gen.sv
// stream_gen: valid-qualified 8-bit burst transmitter.
//
// On a start request in IDLE the burst configuration is captured. One cycle
// later the first beat is driven. Each further beat follows after gap_len idle
// cycles. A one-cycle done pulse follows the last beat. There is no
// backpressure.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      burst request, sampled only when idle
//   burst_len  beats per burst (0 = 256)
//   gap_len    idle cycles between beats (0 = back-to-back)
//   mode       00 increment, 01 constant, 10 LFSR, 11 walking-one
//   seed       first data value (unused for walking-one)
//   data_out   beat data, holds last beat while valid_out is low
//   valid_out  beat qualifier
//   busy       high from first beat through last beat
//   done       one-cycle pulse in the cycle after the last beat
//
// Optional feature macro STREAM_GEN_ABORT_EN adds:
//   abort      cancels a running burst (no done pulse)
//   aborted    one-cycle pulse in the cycle busy drops after an abort
module stream_gen #(
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       burst_len,
  input  logic [GAP_W-1:0] gap_len,
  input  logic [1:0]       mode,
  input  logic [7:0]       seed,
`ifdef STREAM_GEN_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [7:0]       data_out,
  output logic             valid_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state;
  logic [8:0]       rem;       // beats still to emit
  logic [GAP_W-1:0] gap_q;     // captured gap length
  logic [GAP_W-1:0] gap_cnt;   // idle cycles left in current gap
  logic [1:0]       mode_q;
  logic [7:0]       nxt_data;  // value of the next beat to emit
  logic             finish;    // IDLE entered from last beat; closing cycle pending
  logic             abort_hit;

`ifdef STREAM_GEN_ABORT_EN
  // A burst is abortable from acceptance through the cycle showing the last beat.
  always_comb begin
    abort_hit = 1'b0;
    if (abort && (state != IDLE || finish)) abort_hit = 1'b1;
  end
`else
  always_comb begin
    abort_hit = 1'b0;
  end
`endif

  function automatic logic [7:0] advance(input logic [7:0] d, input logic [1:0] m);
    logic [7:0] r;
    r = d;
    unique case (m)
      2'b00:   r = d + 8'd1;
      2'b01:   r = d;
      2'b10:   r = {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
      default: r = {d[6:0], d[7]};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      mode_q    <= '0;
      nxt_data  <= '0;
      finish    <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef STREAM_GEN_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef STREAM_GEN_ABORT_EN
      aborted <= 1'b0;
`endif
      if (abort_hit) begin
`ifdef STREAM_GEN_ABORT_EN
        aborted <= 1'b1;
`endif
        state     <= IDLE;
        finish    <= 1'b0;
        valid_out <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            valid_out <= 1'b0;
            if (finish) begin
              // Cycle showing the last beat: start is still ignored here.
              finish <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else if (start) begin
              rem    <= (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
              gap_q  <= gap_len;
              mode_q <= mode;
              if (mode == 2'b11 || (mode == 2'b10 && seed == 8'h00))
                nxt_data <= 8'h01;
              else
                nxt_data <= seed;
              state <= SEND;
            end
          end
          SEND: begin
            valid_out <= 1'b1;
            busy      <= 1'b1;
            data_out  <= nxt_data;
            nxt_data  <= advance(nxt_data, mode_q);
            rem       <= rem - 9'd1;
            if (rem == 9'd1) begin
              state  <= IDLE;
              finish <= 1'b1;
            end else if (gap_q != '0) begin
              state   <= GAP;
              gap_cnt <= gap_q;
            end
          end
          GAP: begin
            valid_out <= 1'b0;
            if (gap_cnt == GAP_W'(1))
              state <= SEND;
            else
              gap_cnt <= gap_cnt - GAP_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_gen.sv
module tb_stream_gen;
  localparam int unsigned GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       burst_len;
  logic [GAP_W-1:0] gap_len;
  logic [1:0]       mode;
  logic [7:0]       seed;
  logic [7:0]       data_out;
  logic             valid_out;
  logic             busy;
  logic             done;
`ifdef STREAM_GEN_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  stream_gen #(.GAP_W(GAP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .gap_len   (gap_len),
    .mode      (mode),
    .seed      (seed),
`ifdef STREAM_GEN_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  prev_data;
  logic [7:0]  exp_beats[$];
  logic [7:0]  seen[$];
  int unsigned last_t;

  typedef struct {
    logic [1:0]  m;
    logic [7:0]  s;
    logic [7:0]  len;
    logic [3:0]  g;
    bit          noisy;
    bit          chain;
    logic [7:0]  b0, b1, b2;
    int unsigned tlast;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Beat values straight from the pattern definitions.
  task automatic build_beats(input logic [1:0] m, input logic [7:0] s, input int unsigned L);
    logic [7:0] d;
    logic [7:0] one;
    d = 8'h00;
    one = 8'h01;
    exp_beats.delete();
    for (int unsigned k = 0; k < L; k++) begin
      case (m)
        2'b00: exp_beats.push_back(s + 8'(k));
        2'b01: exp_beats.push_back(s);
        2'b10: begin
          if (k == 0) d = (s == 8'h00) ? 8'h01 : s;
          else        d = {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
          exp_beats.push_back(d);
        end
        default: exp_beats.push_back(one << (k % 8));
      endcase
    end
  endtask

  task automatic scramble();
    burst_len = 8'($urandom);
    seed      = 8'($urandom);
    gap_len   = GAP_W'($urandom);
    mode      = 2'($urandom);
  endtask

  task automatic apply_cfg(input logic [1:0] m, input logic [7:0] s, input logic [7:0] len,
                           input logic [GAP_W-1:0] g);
    mode = m; seed = s; burst_len = len; gap_len = g; start = 1'b1;
  endtask

  // Call with start high and configuration applied, before the accepting edge.
  task automatic run_burst(input string tag, input logic [1:0] m, input logic [7:0] s,
                           input logic [7:0] len, input logic [GAP_W-1:0] g, input bit noisy,
                           input bit chain, input logic [1:0] nm, input logic [7:0] ns,
                           input logic [7:0] nlen, input logic [GAP_W-1:0] ng);
    int unsigned L, per, tl, idx;
    logic ev, eb, ed;
    logic [7:0] edata;
    L   = (len == 8'd0) ? 256 : int'(len);
    per = int'(g) + 1;
    tl  = 1 + (L - 1) * per;
    build_beats(m, s, L);
    seen.delete();
    last_t = 0;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    for (int unsigned t = 0; t <= tl + 1; t++) begin
      @(negedge clk);
      ev = (t >= 1 && t <= tl && ((t - 1) % per) == 0);
      eb = (t >= 1 && t <= tl);
      ed = (t == tl + 1);
      if (t == 0) edata = prev_data;
      else begin
        idx = (t - 1) / per;
        if (idx > L - 1) idx = L - 1;
        edata = exp_beats[idx];
      end
      if (valid_out === 1'b1) begin
        seen.push_back(data_out);
        last_t = t;
      end
      chk($sformatf("%s t=%0d {valid,busy,done,data}", tag, t),
          {21'b0, valid_out, busy, done, data_out}, {21'b0, ev, eb, ed, edata});
      if (t <= tl)      start = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
      else if (chain)   apply_cfg(nm, ns, nlen, ng);
      else              start = 1'b0;
    end
    prev_data = exp_beats[L - 1];
    chk({tag, " beat_count"}, seen.size(), L);
  endtask

  vec_t tab[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    logic [7:0] exp3[3];
    rst = 1'b0; start = 1'b0; burst_len = '0; gap_len = '0; mode = '0; seed = '0;
`ifdef STREAM_GEN_ABORT_EN
    abort = 1'b0;
`endif
    prev_data = 8'h00;

    tab[0] = '{2'b00, 8'hFD, 8'd5, 4'd0,  1'b0, 1'b0, 8'hFD, 8'hFE, 8'hFF, 5};
    tab[1] = '{2'b01, 8'hA5, 8'd3, 4'd2,  1'b0, 1'b0, 8'hA5, 8'hA5, 8'hA5, 7};
    tab[2] = '{2'b10, 8'h00, 8'd3, 4'd0,  1'b0, 1'b0, 8'h01, 8'h02, 8'h04, 3};
    tab[3] = '{2'b10, 8'h80, 8'd3, 4'd1,  1'b0, 1'b0, 8'h80, 8'h01, 8'h02, 5};
    tab[4] = '{2'b11, 8'h55, 8'd0, 4'd0,  1'b1, 1'b1, 8'h01, 8'h02, 8'h04, 256};
    tab[5] = '{2'b01, 8'h3C, 8'd4, 4'd15, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h3C, 49};
    tab[6] = '{2'b10, 8'hB8, 8'd3, 4'd0,  1'b0, 1'b0, 8'hB8, 8'h70, 8'hE0, 3};

    #3 rst = 1'b1;
    #1;
    chk("reset_state", {21'b0, valid_out, busy, done, data_out}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {21'b0, valid_out, busy, done, data_out}, 32'h0);

    // Directed table; entry 4 chains straight into entry 5 from its done cycle.
    for (int i = 0; i < 7; i++) begin
      if (i == 0 || !tab[i-1].chain) begin
        @(negedge clk);
        apply_cfg(tab[i].m, tab[i].s, tab[i].len, tab[i].g);
      end
      if (tab[i].chain)
        run_burst($sformatf("vec%0d", i), tab[i].m, tab[i].s, tab[i].len, tab[i].g, tab[i].noisy,
                  1'b1, tab[i+1].m, tab[i+1].s, tab[i+1].len, tab[i+1].g);
      else
        run_burst($sformatf("vec%0d", i), tab[i].m, tab[i].s, tab[i].len, tab[i].g, tab[i].noisy,
                  1'b0, 2'b00, 8'h00, 8'h00, '0);
      exp3[0] = tab[i].b0; exp3[1] = tab[i].b1; exp3[2] = tab[i].b2;
      for (int k = 0; k < 3; k++) begin
        got = (k < seen.size()) ? seen[k] : 8'hxx;
        chk($sformatf("vec%0d beat%0d", i, k), {24'b0, got}, {24'b0, exp3[k]});
      end
      chk($sformatf("vec%0d last_beat_cycle", i), last_t, tab[i].tlast);
    end

    // Reset in the middle of beat 3 of a 10-beat burst, then a fresh burst.
    @(negedge clk);
    apply_cfg(2'b00, 8'h20, 8'd10, 4'd1);
    @(posedge clk); #1 start = 1'b0;
    for (int t = 0; t <= 5; t++) @(negedge clk);
    chk("rst_seq beat3", {23'b0, valid_out, data_out}, {23'b0, 1'b1, 8'h22});
    #2 rst = 1'b1;
    #1;
    chk("rst_seq async_clear", {21'b0, valid_out, busy, done, data_out}, 32'h0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk($sformatf("rst_seq quiet%0d", t), {21'b0, valid_out, busy, done, data_out}, 32'h0);
    end
    prev_data = 8'h00;
    apply_cfg(2'b00, 8'h20, 8'd10, 4'd1);
    run_burst("rst_fresh", 2'b00, 8'h20, 8'd10, 4'd1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, '0);

`ifdef STREAM_GEN_ABORT_EN
    // Abort in the gap after beat 2 of 6 (gap 2 => beat 2 visible at t=4).
    @(negedge clk);
    apply_cfg(2'b00, 8'h40, 8'd6, 4'd2);
    @(posedge clk); #1 start = 1'b0;
    for (int t = 0; t <= 5; t++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort {valid,busy,done,aborted,data}",
        {20'b0, valid_out, busy, done, aborted, data_out}, {20'b0, 4'b0001, 8'h41});
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      chk($sformatf("abort quiet%0d", t), {28'b0, valid_out, busy, done, aborted}, 32'h0);
    end
    prev_data = 8'h41;
`endif

    // Randomized bursts against the reference timeline.
    for (int r = 0; r < 25; r++) begin
      logic [1:0] rm;
      logic [7:0] rs, rl;
      logic [GAP_W-1:0] rg;
      rm = 2'($urandom);
      rs = 8'($urandom);
      rl = 8'($urandom_range(1, 20));
      rg = GAP_W'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      apply_cfg(rm, rs, rl, rg);
      run_burst($sformatf("rnd%0d", r), rm, rs, rl, rg, 1'($urandom), 1'b0,
                2'b00, 8'h00, 8'h00, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
